// File: rtl/rx_aux.sv
//------------------------------------------------------------------------------
// rx_aux : 16x-oversampled UART receiver for the TP2 auxiliary link
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module rx_aux #(
  parameter int   N_BITS_DATA     = 8,
  parameter int   N_CONT_TICKS    = 4,
  parameter int   N_BITS_STATE    = 5,
  parameter logic PARITY_EXPECTED = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   s_ticks,
  input  logic                   rx_data_in,
  output logic [N_BITS_DATA-1:0] rx_data_out,
  output logic                   rx_done,
  output logic                   parity_err,
  output logic                   frame_err
);

  typedef enum logic [N_BITS_STATE-1:0] {
    ST_IDLE   = N_BITS_STATE'(1),
    ST_START  = N_BITS_STATE'(2),
    ST_DATA   = N_BITS_STATE'(4),
    ST_PARITY = N_BITS_STATE'(8),
    ST_STOP   = N_BITS_STATE'(16)
  } state_t;

  localparam logic [N_CONT_TICKS-1:0] C_MID_TICK  = N_CONT_TICKS'(7);
  localparam logic [N_CONT_TICKS-1:0] C_LAST_TICK = '1;
  localparam logic [N_CONT_TICKS-1:0] C_LAST_BIT  = N_CONT_TICKS'(N_BITS_DATA - 1);

  logic                    rx_meta_q, rx_s_q, rx_prev_q;
  logic                    w_fall;
  state_t                  state_q, state_d;
  logic [N_CONT_TICKS-1:0] tick_q, tick_d;
  logic [N_CONT_TICKS-1:0] bit_q, bit_d;
  logic [N_BITS_DATA-1:0]  shift_q, shift_d;
  logic [N_BITS_DATA-1:0]  data_q, data_d;
  logic                    perr_q, perr_d;
  logic                    done_q, done_d;
  logic                    parity_err_q, parity_err_d;
  logic                    frame_err_q, frame_err_d;

  // Synchronizer flops reset high so an idle line never looks like an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_data_in;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign w_fall = rx_prev_q & ~rx_s_q;

  always_comb begin
    state_d      = state_q;
    tick_d       = s_ticks ? tick_q + N_CONT_TICKS'(1) : tick_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    data_d       = data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        if (w_fall) state_d = ST_START;
      end
      ST_START: begin
        if (s_ticks && tick_q == C_MID_TICK) state_d = rx_s_q ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (s_ticks && tick_q == C_LAST_TICK) begin
          shift_d = {rx_s_q, shift_q[N_BITS_DATA-1:1]};
          bit_d   = bit_q + N_CONT_TICKS'(1);
          if (bit_q == C_LAST_BIT) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (s_ticks && tick_q == C_LAST_TICK) begin
          perr_d  = (rx_s_q != PARITY_EXPECTED);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Errored frames are still delivered; the consumer decides what to drop.
        if (s_ticks && tick_q == C_LAST_TICK) begin
          data_d       = shift_q;
          parity_err_d = perr_q;
          frame_err_d  = ~rx_s_q;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      tick_d = '0;
      bit_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      data_q       <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      data_q       <= data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      done_q       <= done_d;
    end
  end

  assign rx_data_out = data_q;
  assign rx_done     = done_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_rx_aux.sv
//------------------------------------------------------------------------------
// tb_rx_aux : self-checking bench for rx_aux (table, corner sequences, random)
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_rx_aux;

  localparam int C_BIT_CLKS = 64;

  logic       clock = 1'b0;
  logic       reset;
  logic       s_ticks = 1'b0;
  logic       rx_data_in;
  logic [7:0] rx_data_out;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;

  rx_aux dut (
    .clock       (clock),
    .reset       (reset),
    .s_ticks     (s_ticks),
    .rx_data_in  (rx_data_in),
    .rx_data_out (rx_data_out),
    .rx_done     (rx_done),
    .parity_err  (parity_err),
    .frame_err   (frame_err)
  );

  always #5 clock = ~clock;

  // One tick every 4 clocks: 16 ticks per 64-clock bit.
  int tick_div = 0;
  always @(negedge clock) begin
    tick_div = (tick_div + 1) % 4;
    s_ticks  = (tick_div == 0);
  end

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stp;
    int         gap_clks;
    logic [7:0] e_data;
    logic       e_perr;
    logic       e_ferr;
  } vec_t;

  exp_t exp_q[$];
  exp_t last = '{8'h00, 1'b0, 1'b0};
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: every frame pushed is delivered once, in order, and the
  // delivered values persist until the next delivery or a reset.
  always @(posedge clock) begin
    #2;
    if (reset) begin
      exp_q.delete();
      last = '{8'h00, 1'b0, 1'b0};
      chk("done_in_reset", {31'b0, rx_done}, 32'd0);
    end else if (rx_done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got rx_done=1 expected no pending frame at %0t", $time);
      end else begin
        last = exp_q.pop_front();
      end
    end
    chk("outputs", {22'b0, rx_data_out, parity_err, frame_err},
        {22'b0, last.data, last.perr, last.ferr});
  end

  task automatic hold_line(input logic v, input int clks);
    rx_data_in = v;
    repeat (clks) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    hold_line(1'b0, C_BIT_CLKS);
    for (int i = 0; i < 8; i++) hold_line(d[i], C_BIT_CLKS);
    hold_line(par, C_BIT_CLKS);
    hold_line(stp, C_BIT_CLKS);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    exp_q.push_back(e);
  endtask

  vec_t tbl[5];

  initial begin
    logic [7:0] rd;
    logic       rp, rs;
    int         gap;

    tbl[0] = '{8'hA5, 1'b0, 1'b1, 128, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 1'b0, 1'b1, 0,   8'h00, 1'b0, 1'b0};
    tbl[2] = '{8'hFF, 1'b0, 1'b1, 128, 8'hFF, 1'b0, 1'b0};
    tbl[3] = '{8'h5A, 1'b1, 1'b1, 128, 8'h5A, 1'b1, 1'b0};
    tbl[4] = '{8'h11, 1'b0, 1'b1, 128, 8'h11, 1'b0, 1'b0};

    reset      = 1'b1;
    rx_data_in = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_data", {24'b0, rx_data_out}, 32'h0);
    chk("reset_flags", {30'b0, parity_err, frame_err}, 32'h0);
    chk("reset_done", {31'b0, rx_done}, 32'h0);
    reset = 1'b0;
    hold_line(1'b1, 2 * C_BIT_CLKS);

    for (int i = 0; i < 5; i++) begin
      push_exp(tbl[i].e_data, tbl[i].e_perr, tbl[i].e_ferr);
      send_frame(tbl[i].data, tbl[i].par, tbl[i].stp);
      chk("tbl_delivered", exp_q.size(), 32'd0);
      chk("tbl_data", {24'b0, rx_data_out}, {24'b0, tbl[i].e_data});
      chk("tbl_perr", {31'b0, parity_err}, {31'b0, tbl[i].e_perr});
      chk("tbl_ferr", {31'b0, frame_err}, {31'b0, tbl[i].e_ferr});
      if (tbl[i].gap_clks > 0) hold_line(1'b1, tbl[i].gap_clks);
    end

    // Short low glitch must be rejected, then a clean frame.
    hold_line(1'b0, 12);
    hold_line(1'b1, 2 * C_BIT_CLKS);
    chk("glitch_no_done", {24'b0, rx_data_out}, 32'h11);
    push_exp(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1);
    chk("glitch_next_frame", exp_q.size(), 32'd0);
    chk("glitch_next_data", {24'b0, rx_data_out}, 32'h3C);
    hold_line(1'b1, 2 * C_BIT_CLKS);

    // Framing error followed by a long break; no retrigger while low.
    push_exp(8'h81, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b0);
    chk("break_delivered", exp_q.size(), 32'd0);
    chk("break_ferr", {31'b0, frame_err}, 32'd1);
    hold_line(1'b0, 40 * C_BIT_CLKS);
    chk("break_hold_data", {24'b0, rx_data_out}, 32'h81);
    hold_line(1'b1, 2 * C_BIT_CLKS);
    push_exp(8'h7E, 1'b0, 1'b0);
    send_frame(8'h7E, 1'b0, 1'b1);
    chk("after_break_delivered", exp_q.size(), 32'd0);
    chk("after_break_ferr", {31'b0, frame_err}, 32'd0);
    chk("after_break_data", {24'b0, rx_data_out}, 32'h7E);
    hold_line(1'b1, 2 * C_BIT_CLKS);

    // Reset in the middle of data bit 4 aborts the frame.
    rd = 8'h96;
    hold_line(1'b0, C_BIT_CLKS);
    for (int i = 0; i < 4; i++) hold_line(rd[i], C_BIT_CLKS);
    hold_line(rd[4], C_BIT_CLKS / 2);
    rx_data_in = 1'b1;
    reset      = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_data_zero", {24'b0, rx_data_out}, 32'h0);
    chk("abort_flags_zero", {30'b0, parity_err, frame_err}, 32'h0);
    hold_line(1'b1, 4 * C_BIT_CLKS);
    chk("abort_no_done", {24'b0, rx_data_out}, 32'h0);
    push_exp(8'hC3, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1);
    chk("abort_next_delivered", exp_q.size(), 32'd0);
    chk("abort_next_data", {24'b0, rx_data_out}, 32'hC3);
    hold_line(1'b1, C_BIT_CLKS);

    // Random frames: model derives flags from the slot values.
    for (int n = 0; n < 24; n++) begin
      rd  = 8'($urandom);
      rp  = ($urandom_range(0, 3) == 0);
      rs  = ($urandom_range(0, 3) != 0);
      gap = rs ? int'($urandom_range(0, 100)) : int'($urandom_range(4, 100));
      push_exp(rd, rp != 1'b0, rs == 1'b0);
      send_frame(rd, rp, rs);
      chk("rand_delivered", exp_q.size(), 32'd0);
      if (gap > 0) hold_line(1'b1, gap);
    end

    hold_line(1'b1, 4 * C_BIT_CLKS);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
